// File: rtl/messbauer_diff_discriminator_burst_gen.sv
// Differential-discriminator stimulus source: on each accepted channel strobe, emits a burst of
// lower/upper threshold impulse pairs with a selectable count of lower-only (selected) impulses.
module messbauer_diff_discriminator_burst_gen #(
  parameter int COUNTER_WIDTH            = 8,
  parameter int LOWER_THRESHOLD_DURATION = 3,
  parameter int UPPER_THRESHOLD_DELAY    = 1,
  parameter int UPPER_THRESHOLD_DURATION = 1,
  parameter int IMPULSES_PAUSE           = 10,
  parameter int SELECTION_MODE           = 0
) (
  input  logic                     aclk,
  input  logic                     areset_n,
  input  logic                     enable,
  input  logic                     channel,
  input  logic [COUNTER_WIDTH-1:0] impulses_per_channel,
  input  logic [COUNTER_WIDTH-1:0] impulses_for_selection,
  output logic                     lower_threshold,
  output logic                     upper_threshold,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun,
  output logic [COUNTER_WIDTH-1:0] impulse_count
);

  localparam int CW     = COUNTER_WIDTH;
  localparam int T_MAX  = (LOWER_THRESHOLD_DURATION > IMPULSES_PAUSE) ?
                          LOWER_THRESHOLD_DURATION : IMPULSES_PAUSE;
  localparam int TW     = $clog2(T_MAX + 1);
  localparam int UP_LO  = UPPER_THRESHOLD_DELAY;
  localparam int UP_HI  = UPPER_THRESHOLD_DELAY + UPPER_THRESHOLD_DURATION - 1;
  localparam logic [TW-1:0] PULSE_LAST = TW'(LOWER_THRESHOLD_DURATION - 1);
  localparam logic [TW-1:0] PAUSE_LAST = TW'(IMPULSES_PAUSE - 1);

  typedef enum logic [1:0] {IDLE, PULSE, PAUSE, DONE} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [CW-1:0]   n_q, n_d;
  logic [CW-1:0]   s_q, s_d;
  logic [CW-1:0]   count_q, count_d;
  logic            lower_d, upper_d, busy_d, done_d, overrun_d;
  logic            rejected_d;

  // Next-state logic.
  // NOTE: every variable gets a default at the top of the block so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    n_d       = n_q;
    s_d       = s_q;
    count_d   = count_q;
    overrun_d = channel && ((state_q == PULSE) || (state_q == PAUSE));

    case (state_q)
      IDLE, DONE: begin
        // DONE behaves like IDLE for strobe acceptance, so back-to-back channels are not lost.
        state_d = IDLE;
        if (channel && enable) begin
          n_d     = impulses_per_channel;
          s_d     = (impulses_for_selection > impulses_per_channel) ?
                    impulses_per_channel : impulses_for_selection;
          count_d = '0;
          timer_d = '0;
          state_d = (impulses_per_channel == '0) ? DONE : PULSE;
        end
      end
      PULSE: begin
        if (timer_q == PULSE_LAST) begin
          timer_d = '0;
          count_d = count_q + CW'(1);
          state_d = PAUSE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      PAUSE: begin
        if (timer_q == PAUSE_LAST) begin
          timer_d = '0;
          state_d = ((count_q == n_q) || !enable) ? DONE : PULSE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so they can be registered without extra latency.
  always_comb begin
    if (SELECTION_MODE == 0) begin
      rejected_d = !(count_d < s_d);
    end else begin
      rejected_d = !(count_d >= (n_d - s_d));
    end
    lower_d = (state_d == PULSE);
    upper_d = lower_d && rejected_d &&
              (int'(timer_d) >= UP_LO) && (int'(timer_d) <= UP_HI);
    busy_d  = (state_d == PULSE) || (state_d == PAUSE);
    done_d  = (state_d == DONE);
  end

  // NOTE: state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q         <= IDLE;
      timer_q         <= '0;
      n_q             <= '0;
      s_q             <= '0;
      count_q         <= '0;
      lower_threshold <= 1'b0;
      upper_threshold <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      n_q             <= n_d;
      s_q             <= s_d;
      count_q         <= count_d;
      lower_threshold <= lower_d;
      upper_threshold <= upper_d;
      busy            <= busy_d;
      done            <= done_d;
      overrun         <= overrun_d;
    end
  end

  assign impulse_count = count_q;

endmodule

// File: tb/tb_messbauer_diff_discriminator_burst_gen.sv
// Bench for the burst generator: two instances (first-N and last-N selection) checked every cycle
// against a timing model derived from burst start time, impulse period and latched N/S.
module tb_messbauer_diff_discriminator_burst_gen;

  localparam int CW  = 8;
  localparam int L   = 3;
  localparam int D   = 1;
  localparam int U   = 1;
  localparam int P   = 10;
  localparam int PER = L + P;

  logic          aclk     = 1'b0;
  logic          areset_n = 1'b0;
  logic          enable   = 1'b0;
  logic          channel  = 1'b0;
  logic [CW-1:0] ipc      = '0;
  logic [CW-1:0] ifs      = '0;

  logic          lower   [2];
  logic          upper   [2];
  logic          busy    [2];
  logic          done    [2];
  logic          overrun [2];
  logic [CW-1:0] icount  [2];

  messbauer_diff_discriminator_burst_gen #(
    .COUNTER_WIDTH(CW), .LOWER_THRESHOLD_DURATION(L), .UPPER_THRESHOLD_DELAY(D),
    .UPPER_THRESHOLD_DURATION(U), .IMPULSES_PAUSE(P), .SELECTION_MODE(0)
  ) dut0 (
    .aclk(aclk), .areset_n(areset_n), .enable(enable), .channel(channel),
    .impulses_per_channel(ipc), .impulses_for_selection(ifs),
    .lower_threshold(lower[0]), .upper_threshold(upper[0]), .busy(busy[0]),
    .done(done[0]), .overrun(overrun[0]), .impulse_count(icount[0])
  );

  messbauer_diff_discriminator_burst_gen #(
    .COUNTER_WIDTH(CW), .LOWER_THRESHOLD_DURATION(L), .UPPER_THRESHOLD_DELAY(D),
    .UPPER_THRESHOLD_DURATION(U), .IMPULSES_PAUSE(P), .SELECTION_MODE(1)
  ) dut1 (
    .aclk(aclk), .areset_n(areset_n), .enable(enable), .channel(channel),
    .impulses_per_channel(ipc), .impulses_for_selection(ifs),
    .lower_threshold(lower[1]), .upper_threshold(upper[1]), .busy(busy[1]),
    .done(done[1]), .overrun(overrun[1]), .impulse_count(icount[1])
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  // Model: a burst is described by the cycle of its first lower cycle plus latched N and S.
  int cyc     = 0;
  int rel     = 0;
  bit m_busy  = 0;
  bit m_done  = 0;
  bit m_ovr   = 0;
  int m_start = 0;
  int m_n     = 0;
  int m_s     = 0;
  int m_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit is_rejected(input int mode, input int k);
    if (mode == 0) return !(k < m_s);
    return !(k >= m_n - m_s);
  endfunction

  task automatic model_reset();
    m_busy = 0;
    m_done = 0;
    m_ovr  = 0;
    m_cnt  = 0;
  endtask

  // Advance the model across one clock edge using the inputs held during cycle cyc.
  task automatic model_step();
    bit nb, nd;
    int r, k, ph;
    nb    = m_busy;
    nd    = 0;
    m_ovr = channel && m_busy;
    if (m_busy) begin
      r  = cyc - m_start;
      k  = r / PER;
      ph = r % PER;
      if (ph == PER - 1 && (k + 1 == m_n || !enable)) begin
        nb    = 0;
        nd    = 1;
        m_cnt = k + 1;
      end
    end else if (channel && enable) begin
      m_n   = int'(ipc);
      m_s   = (ifs > ipc) ? int'(ipc) : int'(ifs);
      m_cnt = 0;
      if (ipc == 0) nd = 1;
      else begin
        nb      = 1;
        m_start = cyc + 1;
      end
    end
    cyc++;
    m_busy = nb;
    m_done = nd;
  endtask

  task automatic compare_all();
    int r, k, ph, el, eu, ec;
    for (int m = 0; m < 2; m++) begin
      if (m_busy) begin
        r  = cyc - m_start;
        k  = r / PER;
        ph = r % PER;
        el = (ph < L) ? 1 : 0;
        eu = (el == 1 && is_rejected(m, k) && ph >= D && ph < D + U) ? 1 : 0;
        ec = k + ((ph >= L) ? 1 : 0);
      end else begin
        el = 0;
        eu = 0;
        ec = m_cnt;
      end
      check($sformatf("lower_m%0d", m),   32'(lower[m]),   32'(el));
      check($sformatf("upper_m%0d", m),   32'(upper[m]),   32'(eu));
      check($sformatf("busy_m%0d", m),    32'(busy[m]),    32'(m_busy));
      check($sformatf("done_m%0d", m),    32'(done[m]),    32'(m_done));
      check($sformatf("overrun_m%0d", m), 32'(overrun[m]), 32'(m_ovr));
      check($sformatf("count_m%0d", m),   32'(icount[m]),  32'(ec));
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    model_step();
    #1;
    compare_all();
    channel = 1'b0;
    rel++;
  endtask

  task automatic strobe(input int n, input int s);
    ipc     = CW'(n);
    ifs     = CW'(s);
    channel = 1'b1;
    rel     = 0;
    tick();
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge aclk);
    #1;
    for (int m = 0; m < 2; m++) begin
      check("rst_lower", 32'(lower[m]), 32'd0);
      check("rst_busy",  32'(busy[m]),  32'd0);
      check("rst_count", 32'(icount[m]), 32'd0);
    end
    areset_n = 1'b1;
    model_reset();
    enable = 1'b1;
    repeat (3) tick();

    // N=4 S=1, overrun at cycle 20, back-to-back strobe in done cycle 53
    strobe(4, 1);
    for (int i = 0; i < 52; i++) begin
      tick();
      if (rel == 2) begin
        check("t1_upper_c2_m0", 32'(upper[0]), 32'd0);
        check("t3_upper_c2_m1", 32'(upper[1]), 32'd1);
      end
      if (rel == 15) check("t1_upper_c15_m0", 32'(upper[0]), 32'd1);
      if (rel == 21) check("t5_overrun_c21", 32'(overrun[0]), 32'd1);
      if (rel == 41) check("t3_upper_c41_m1", 32'(upper[1]), 32'd0);
      if (rel == 20) begin
        channel = 1'b1;
        ipc     = 8'd7;
        ifs     = 8'd0;
      end
    end
    check("t1_done_c53", 32'(done[0]), 32'd1);
    check("t1_count_c53", 32'(icount[0]), 32'd4);
    ipc     = 8'd2;
    ifs     = 8'd0;
    channel = 1'b1;
    tick();
    check("t5_lower_c54", 32'(lower[0]), 32'd1);
    repeat (30) tick();

    // Selection clamp: S > N
    strobe(3, 5);
    repeat (39) tick();
    check("t2_done_c40", 32'(done[0]), 32'd1);
    repeat (3) tick();

    // N = 0
    strobe(0, 0);
    check("t4_done_c1", 32'(done[0]), 32'd1);
    check("t4_busy_c1", 32'(busy[0]), 32'd0);
    repeat (3) tick();

    // Async reset in the middle of a rejected impulse
    strobe(4, 1);
    repeat (14) tick();
    check("t6_upper_c15", 32'(upper[0]), 32'd1);
    #2 areset_n = 1'b0;
    #1;
    check("t6_rst_lower", 32'(lower[0]), 32'd0);
    check("t6_rst_upper", 32'(upper[0]), 32'd0);
    check("t6_rst_busy",  32'(busy[0]),  32'd0);
    model_reset();
    @(posedge aclk);
    @(posedge aclk);
    #1 areset_n = 1'b1;
    cyc += 2;
    repeat (2) tick();
    strobe(2, 1);
    repeat (30) tick();

    // Enable dropped mid-burst
    strobe(4, 1);
    for (int i = 0; i < 13; i++) begin
      tick();
      if (rel == 5) enable = 1'b0;
    end
    check("t6_en_done_c14", 32'(done[0]), 32'd1);
    check("t6_en_count_c14", 32'(icount[0]), 32'd1);
    enable = 1'b1;
    repeat (3) tick();

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      channel = ($urandom_range(0, 14) == 0);
      ipc     = CW'($urandom_range(0, 5));
      ifs     = CW'($urandom_range(0, 7));
      enable  = ($urandom_range(0, 39) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
